// File: rtl/pulseox_fft_pkg.sv
// Shared types and helpers for the pulse-ox post-FFT spectral path.
// Holds default geometry, the analyser FSM states and BPM scaling.
package pulseox_fft_pkg;

  localparam int DATA_W_DEF    = 22;
  localparam int NFFT_DEF      = 1024;
  localparam int BPM_SCALE_DEF = 192000;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_t;

  // (bin * scale) >> 16, clamped to the 10-bit BPM range
  function automatic logic [9:0] bpm_sat(
    input logic [15:0] bin,
    input logic [19:0] scale
  );
    logic [35:0] prod;
    prod = (36'(bin) * 36'(scale)) >> 16;
    if (prod > 36'd1023) return 10'd1023;
    return prod[9:0];
  endfunction

endpackage

// File: rtl/mag_sqrt_pipe.sv
// Fully pipelined floor integer square root, one result per cycle.
// A sideband word travels in lockstep with each radicand.
module mag_sqrt_pipe #(
  parameter int INPUT_BITS  = 44,
  parameter int OUTPUT_BITS = 22,
  parameter int SIDE_W      = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [INPUT_BITS-1:0]  in_data,
  input  logic [SIDE_W-1:0]      in_side,
  output logic                   out_valid,
  output logic [OUTPUT_BITS-1:0] out_root,
  output logic [SIDE_W-1:0]      out_side
);

  localparam int N     = OUTPUT_BITS;
  localparam int REM_W = N + 2;
  localparam int SH_W  = REM_W + 2;

  logic [INPUT_BITS-1:0] x_q    [0:N-1];
  logic [REM_W-1:0]      rem_q  [0:N-1];
  logic [N-1:0]          root_q [0:N];
  logic [SIDE_W-1:0]     side_q [0:N];
  logic [N:0]            v_q;

  logic [SH_W-1:0] rem_sh [1:N];
  logic [SH_W-1:0] trial  [1:N];
  logic [N:1]      fits;

  // One result bit per stage, MSB first
  always_comb begin
    for (int k = 1; k <= N; k++) begin
      rem_sh[k] = {rem_q[k-1], x_q[k-1][INPUT_BITS-1 -: 2]};
      trial[k]  = {2'b00, root_q[k-1], 2'b01};
      fits[k]   = rem_sh[k] >= trial[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int k = 0; k < N; k++) begin
        x_q[k]   <= '0;
        rem_q[k] <= '0;
      end
      for (int k = 0; k <= N; k++) begin
        root_q[k] <= '0;
        side_q[k] <= '0;
      end
    end else begin
      v_q       <= {v_q[N-1:0], in_valid};
      x_q[0]    <= in_data;
      rem_q[0]  <= '0;
      root_q[0] <= '0;
      side_q[0] <= in_side;
      for (int k = 1; k < N; k++) begin
        x_q[k]   <= x_q[k-1] << 2;
        rem_q[k] <= fits[k] ?
          REM_W'(rem_sh[k] - trial[k]) :
          REM_W'(rem_sh[k]);
      end
      for (int k = 1; k <= N; k++) begin
        root_q[k] <= {root_q[k-1][N-2:0], fits[k]};
        side_q[k] <= side_q[k-1];
      end
    end
  end

  assign out_valid = v_q[N];
  assign out_root  = root_q[N];
  assign out_side  = side_q[N];

endmodule

// File: rtl/fft_spectrum_peak_finder.sv
// Post-FFT analyser: per-bin magnitude, DC level and in-band HR peak.
// Frames may be gapped, aborted by a new SOP, or overlap during drain.
module fft_spectrum_peak_finder
  import pulseox_fft_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NFFT       = NFFT_DEF,
  parameter int NBINS_USED = 512,
  parameter int BIN_LO     = 4,
  parameter int BIN_HI     = 40,
  parameter int BPM_SCALE  = BPM_SCALE_DEF,
  parameter int BIN_W      = $clog2(NFFT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic [DATA_W-1:0] out_dc,
  output logic [DATA_W-1:0] out_ac,
  output logic [BIN_W-1:0]  out_hr_bin,
  output logic [9:0]        out_hr_bpm,
  output logic              out_valid,
  output logic              frame_abort,
  output logic              busy
);

  localparam int SQ_W   = 2 * DATA_W - 1;
  localparam int MAG2_W = 2 * DATA_W;
  localparam int SIDE_W = BIN_W + 2;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NBINS_USED - 1);
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(NFFT - 1);
  localparam logic [BIN_W-1:0] LO_BIN   = BIN_W'(BIN_LO);
  localparam logic [BIN_W-1:0] HI_BIN   = BIN_W'(BIN_HI);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] cnt_q, cnt_d;
  logic             tag_q, tag_d;
  logic             sop, start, issue, abort_d;
  logic [BIN_W-1:0] beat_bin;
  logic             beat_last;

  logic             done_q, done_tag_q;

  assign sop       = in_valid & in_sop;
  assign beat_last = beat_bin == LAST_BIN;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    start    = 1'b0;
    issue    = 1'b0;
    abort_d  = 1'b0;
    beat_bin = cnt_q;
    unique case (state_q)
      IDLE: start = sop;
      COLLECT: begin
        start   = sop;
        abort_d = sop;
        if (in_valid && !in_sop) begin
          issue = 1'b1;
          cnt_d = (cnt_q == MAX_BIN) ? cnt_q : cnt_q + 1'b1;
          if (cnt_q == LAST_BIN) state_d = DRAIN;
        end
      end
      DRAIN: begin
        start = sop;
        // Leave only once the frame that entered drain has reported
        if (done_q && done_tag_q == tag_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      issue    = 1'b1;
      beat_bin = '0;
      tag_d    = ~tag_q;
      cnt_d    = BIN_W'(1);
      state_d  = (LAST_BIN == '0) ? DRAIN : COLLECT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tag_q       <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      frame_abort <= abort_d;
    end
  end

  assign busy = state_q != IDLE;

  logic [DATA_W-1:0] re_abs, im_abs;
  logic [SQ_W-1:0]   re_sq, im_sq;

  assign re_abs = in_re[DATA_W-1] ? DATA_W'(-in_re) : in_re;
  assign im_abs = in_im[DATA_W-1] ? DATA_W'(-in_im) : in_im;
  assign re_sq  = SQ_W'(re_abs) * SQ_W'(re_abs);
  assign im_sq  = SQ_W'(im_abs) * SQ_W'(im_abs);

  logic              s1_v, s2_v;
  logic [SQ_W-1:0]   s1_re2, s1_im2;
  logic [SIDE_W-1:0] s1_side, s2_side;
  logic [MAG2_W-1:0] s2_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v    <= 1'b0;
      s1_re2  <= '0;
      s1_im2  <= '0;
      s1_side <= '0;
      s2_v    <= 1'b0;
      s2_mag  <= '0;
      s2_side <= '0;
    end else begin
      s1_v    <= issue;
      s1_re2  <= re_sq;
      s1_im2  <= im_sq;
      s1_side <= {beat_bin, beat_last, tag_d};
      s2_v    <= s1_v;
      s2_mag  <= MAG2_W'(s1_re2) + MAG2_W'(s1_im2);
      s2_side <= s1_side;
    end
  end

  logic              sq_v;
  logic [DATA_W-1:0] sq_root;
  logic [SIDE_W-1:0] sq_side;

  mag_sqrt_pipe #(
    .INPUT_BITS (MAG2_W),
    .OUTPUT_BITS(DATA_W),
    .SIDE_W     (SIDE_W)
  ) u_sqrt (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (s2_v),
    .in_data  (s2_mag),
    .in_side  (s2_side),
    .out_valid(sq_v),
    .out_root (sq_root),
    .out_side (sq_side)
  );

  logic [BIN_W-1:0]  sq_bin;
  logic              sq_last, sq_tag, sq_hit, in_band;
  logic              trk_tag;
  logic [DATA_W-1:0] dc_q, pk_q;
  logic [BIN_W-1:0]  pkb_q;

  assign sq_bin  = sq_side[SIDE_W-1:2];
  assign sq_last = sq_side[1];
  assign sq_tag  = sq_side[0];
  // Bin 0 opens a frame; leftovers of an aborted frame carry a stale tag
  assign sq_hit  = sq_v & ((sq_bin == '0) | (sq_tag == trk_tag));
  assign in_band = (sq_bin >= LO_BIN) & (sq_bin <= HI_BIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trk_tag    <= 1'b0;
      dc_q       <= '0;
      pk_q       <= '0;
      pkb_q      <= LO_BIN;
      done_q     <= 1'b0;
      done_tag_q <= 1'b0;
    end else begin
      done_q     <= sq_hit & sq_last;
      done_tag_q <= sq_tag;
      if (sq_v && sq_bin == '0) begin
        trk_tag <= sq_tag;
        dc_q    <= sq_root;
        pk_q    <= '0;
        pkb_q   <= LO_BIN;
      end else if (sq_hit && in_band && sq_root > pk_q) begin
        pk_q  <= sq_root;
        pkb_q <= sq_bin;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_dc     <= '0;
      out_ac     <= '0;
      out_hr_bin <= '0;
      out_hr_bpm <= '0;
    end else begin
      out_valid <= done_q;
      if (done_q) begin
        out_dc     <= dc_q;
        out_ac     <= pk_q;
        out_hr_bin <= pkb_q;
        out_hr_bpm <= bpm_sat(16'(pkb_q), 20'(BPM_SCALE));
      end
    end
  end

endmodule

// File: tb/tb_fft_spectrum_peak_finder.sv
// Scoreboard bench for fft_spectrum_peak_finder with a behavioural
// magnitude/peak model, directed corner frames and random gapped traffic.
module tb_fft_spectrum_peak_finder;

  localparam int DW  = 22;
  localparam int NB  = 512;
  localparam int LO  = 4;
  localparam int HI  = 40;
  localparam int LAT = 26;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_sop = 1'b0;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic [DW-1:0]        out_dc, out_ac;
  logic [9:0]           out_hr_bin, out_hr_bpm;
  logic                 out_valid, frame_abort, busy;

  fft_spectrum_peak_finder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_re      (in_re),
    .in_im      (in_im),
    .out_dc     (out_dc),
    .out_ac     (out_ac),
    .out_hr_bin (out_hr_bin),
    .out_hr_bpm (out_hr_bpm),
    .out_valid  (out_valid),
    .frame_abort(frame_abort),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int dc;
    int ac;
    int bin;
    int bpm;
    int edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t nxt;
  int   checks = 0;
  int   fails = 0;
  int   out_cnt = 0;
  int   abort_cnt = 0;
  int   abort_cyc = -1;
  int   first_edge = 0;
  int   fre[NB];
  int   fim[NB];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && frame_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (reset_n && out_valid) begin
      out_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_dc", out_dc, e.dc);
        chk("out_ac", out_ac, e.ac);
        chk("out_hr_bin", out_hr_bin, e.bin);
        chk("out_hr_bpm", out_hr_bpm, e.bpm);
        chk("latency", cyc - e.edge_n, LAT);
      end
    end
  end

  function automatic longint isqrt(input longint n);
    longint lo, hi, mid;
    lo = 0;
    hi = 64'd4194304;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic int mag(input int k);
    return int'(isqrt(longint'(fre[k]) * fre[k] + longint'(fim[k]) * fim[k]));
  endfunction

  function automatic int bpm_of(input int bin);
    longint b;
    b = (longint'(bin) * 192000) / 65536;
    return (b > 1023) ? 1023 : int'(b);
  endfunction

  task automatic model_expect();
    int pk, pb, m;
    pk = 0;
    pb = LO;
    for (int b = LO; b <= HI; b++) begin
      m = mag(b);
      if (m > pk) begin
        pk = m;
        pb = b;
      end
    end
    nxt.dc  = mag(0);
    nxt.ac  = pk;
    nxt.bin = pb;
    nxt.bpm = bpm_of(pb);
  endtask

  task automatic set_exp(input int dc, input int ac, input int bin, input int bpm);
    nxt.dc  = dc;
    nxt.ac  = ac;
    nxt.bin = bin;
    nxt.bpm = bpm;
  endtask

  function automatic int rnd_val();
    case ($urandom_range(0, 3))
      0:       return 0;
      1, 3:    return int'($urandom_range(0, 2000)) - 1000;
      default: return int'($urandom_range(0, 4194303)) - 2097152;
    endcase
  endfunction

  task automatic clear_frame();
    for (int k = 0; k < NB; k++) begin
      fre[k] = 0;
      fim[k] = 0;
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < NB; k++) begin
      fre[k] = rnd_val();
      fim[k] = rnd_val();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sop   = 1'($urandom_range(0, 1));
      in_re    = DW'($urandom);
      in_im    = DW'($urandom);
    end
  endtask

  task automatic beat(input bit sop, input int re, input int im);
    @(negedge clk);
    in_valid = 1'b1;
    in_sop   = sop;
    in_re    = DW'(re);
    in_im    = DW'(im);
  endtask

  task automatic send_frame(input int gap_pct, input int nbeats, input bit push);
    for (int k = 0; k < nbeats; k++) begin
      while ($urandom_range(0, 99) < gap_pct) idle(1);
      beat(k == 0, fre[k], fim[k]);
      if (k == 0) first_edge = cyc + 1;
      if (k == NB - 1 && push) begin
        nxt.edge_n = cyc + 1;
        sb.push_back(nxt);
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_frame_abort"}, frame_abort, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_dc"}, out_dc, 0);
    chk({tag, "_out_ac"}, out_ac, 0);
    chk({tag, "_out_hr_bin"}, out_hr_bin, 0);
    chk({tag, "_out_hr_bpm"}, out_hr_bpm, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sop_b, outs0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    idle(2);

    clear_frame();
    fre[0] = 3000;  fim[0] = 4000;
    fre[25] = -600; fim[25] = 800;
    set_exp(5000, 1000, 25, 73);
    send_frame(0, NB, 1);
    idle(1);
    chk("busy_in_drain", busy, 1);
    wait_drain();
    idle(2);
    chk("busy_after_result", busy, 0);

    clear_frame();
    fre[3] = 9000; fre[60] = 9000; fre[30] = 100;
    set_exp(0, 100, 30, 87);
    send_frame(0, NB, 1);

    clear_frame();
    fim[0] = 7;
    set_exp(7, 0, LO, 11);
    send_frame(0, NB, 1);

    clear_frame();
    fim[12] = -500; fre[20] = 500;
    set_exp(0, 500, 12, 35);
    send_frame(0, NB, 1);

    clear_frame();
    fre[4] = 77; fre[40] = 76; fre[41] = 2097151;
    set_exp(0, 77, 4, 11);
    send_frame(0, NB, 1);

    clear_frame();
    fre[0] = -2097152;  fim[0] = -2097152;
    fre[40] = -2097152; fim[40] = -2097152;
    set_exp(2965820, 2965820, 40, 117);
    send_frame(0, NB, 1);
    idle(1);
    wait_drain();

    rand_frame();
    outs0 = out_cnt;
    send_frame(0, 200, 0);
    clear_frame();
    fre[0] = 30; fim[0] = 40;
    fim[7] = 1234; fre[60] = 5000;
    set_exp(50, 1234, 7, 20);
    send_frame(0, NB, 1);
    sop_b = first_edge;
    idle(1);
    wait_drain();
    idle(5);
    chk("abort_pulses", abort_cnt, 1);
    chk("abort_cycle", abort_cyc, sop_b);
    chk("outputs_after_abort", out_cnt - outs0, 1);

    for (int f = 0; f < 4; f++) begin
      rand_frame();
      model_expect();
      send_frame(50, NB, 1);
    end
    idle(1);
    wait_drain();

    rand_frame();
    outs0 = out_cnt;
    send_frame(30, 300, 0);
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(80);
    chk("no_output_after_reset", out_cnt - outs0, 0);

    rand_frame();
    model_expect();
    send_frame(50, NB, 1);
    idle(1);
    wait_drain();
    idle(5);
    chk("total_abort_pulses", abort_cnt, 1);
    chk("busy_at_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/fft_spectrum_peak_finder.md
Name: fft_spectrum_peak_finder

Overview:
Post-FFT spectral analyser for the pulse-ox path. It consumes a streamed complex FFT frame and forms the integer magnitude of each used bin through an internal pipelined square root. From those magnitudes it reports the DC magnitude (bin 0), the peak AC magnitude inside a configurable heart-rate bin band, the peak bin index and a scaled BPM value. It is the parametrised successor of the fixed 44-bit post-FFT buffer, adding frame abort, gapped input and band limits. It sits between the FFT core and the SpO2/HR calculation logic.

Parameters:
DATA_W, 22, signed width of each real/imag input component
NFFT, 1024, FFT frame length in bins
NBINS_USED, 512, bins evaluated per frame (bins 0..NBINS_USED-1); must be <= NFFT
BIN_LO, 4, lowest bin of the HR search band (inclusive); must be >= 1
BIN_HI, 40, highest bin of the HR search band (inclusive); must be < NBINS_USED
BPM_SCALE, 192000, BPM per bin in unsigned Q16 (50 Hz / 1024 * 60)
BIN_W, $clog2(NFFT), bin index width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input bin qualifier; gaps allowed
in_sop  in  1  first bin of a frame; sampled only when in_valid=1
in_re  in  DATA_W  signed real part
in_im  in  DATA_W  signed imaginary part
out_dc  out  DATA_W  magnitude of bin 0
out_ac  out  DATA_W  peak magnitude within BIN_LO..BIN_HI
out_hr_bin  out  BIN_W  bin index of out_ac
out_hr_bpm  out  10  (out_hr_bin*BPM_SCALE)>>16, saturated to 1023
out_valid  out  1  one-cycle result strobe
frame_abort  out  1  one-cycle pulse when a frame is abandoned
busy  out  1  high from accepted SOP until out_valid or abort

Behaviour:
- Reset is asynchronous on reset_n, active-low, clock clk. On reset all outputs = 0, state = IDLE, all pipeline valids cleared.
- Applying reset mid-frame discards everything in flight; no out_valid or frame_abort follows.
- States are IDLE, COLLECT and DRAIN.
- IDLE: in_valid&in_sop -> COLLECT, with bin counter = 0 and this beat taken as bin 0. Beats with in_valid and no SOP are ignored.
- COLLECT: each in_valid beat is bin k = counter. The counter increments and saturates at NFFT-1.
- COLLECT, in_valid&in_sop: the current frame is aborted. frame_abort pulses, the peak trackers are flushed, and this beat starts a new frame as bin 0.
- Bins k >= NBINS_USED are not issued to the pipeline.
- When bin NBINS_USED-1 is issued -> DRAIN.
- DRAIN: in_valid&in_sop during drain starts a new COLLECT frame. The previous result must still complete, so each pipeline beat carries a frame tag bit.
- Arithmetic, cycle 1: re*re and im*im, each 2*DATA_W-1 bits unsigned.
- Arithmetic, cycle 2: their sum, MAG2_W = 2*DATA_W bits. (-2^(DATA_W-1))^2 twice = 2^(2*DATA_W-1), which fits in MAG2_W.
- Arithmetic, sqrt: floor integer root, OUT_W = DATA_W bits, latency DATA_W+1, throughput 1 per cycle.
- Arithmetic, cycle final: compare/update register.
- Bin index and last/tag flags travel alongside the data.
- Latency: out_valid asserts exactly DATA_W+4 cycles (26 at default) after the in_valid beat carrying bin NBINS_USED-1. The out_* registers hold until the next out_valid.
- Peak rule: a magnitude replaces the current peak only if strictly greater, so ties keep the lowest bin. A band of all zeros reports out_ac=0 and out_hr_bin=BIN_LO.
- Bins outside BIN_LO..BIN_HI (other than bin 0) never affect the outputs.
- BPM: the 36-bit product is right-shifted by 16 and saturated to 10 bits. It is registered together with out_hr_bin.

Decomposition:
- Shared package pulseox_fft_pkg holds:
  - default DATA_W, NFFT and BPM_SCALE
  - the state enum {IDLE, COLLECT, DRAIN}
  - a function computing the saturated BPM.
- One sub-module, mag_sqrt_pipe (parametrised INPUT_BITS/OUTPUT_BITS):
  - asynchronous reset
  - carries a sideband of width BIN_W+2 (bin, last, tag) in lockstep
  - final stage is floor, with no rounding compare.

Test Plan:
- Single frame, default params: bin0=(3000,4000), bin25=(-600,800), all others 0 -> out_dc=5000, out_ac=1000, out_hr_bin=25, out_hr_bpm=73; out_valid exactly 26 cycles after bin 511.
- Out-of-band peak: bin3=(9000,0), bin60=(9000,0), bin30=(100,0) -> out_ac=100, out_hr_bin=30.
- Tie: bin12=(0,-500) and bin20=(500,0) -> out_hr_bin=12, out_ac=500.
- Extreme values: bin0=(-2^21,-2^21) -> out_dc=2965820 (floor sqrt(2^43)), no overflow.
- Abort: SOP at bin 200 of frame A, then full frame B with a peak at bin 7 -> frame_abort pulse at the SOP cycle, exactly one out_valid, carrying B's values (out_hr_bin=7).
- Gapped and back-to-back frames:
  - in_valid with 50% random gaps, SOP for the next frame during DRAIN -> two correct out_valids in order.
  - reset_n low at bin 300 -> no output, all outputs 0.
